// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell and a carry flop consume the operands LSB-first,
// one bit per clock, and publish {carry_out, sum_out} with a single-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] r_sh_d;

    always_comb begin
        s_d    = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
        c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        r_sh_d = {s_d, r_sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        c_q     <= cin_in;
                        cnt_q   <= '0;
                        r_sh_q  <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    c_q    <= c_d;
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    r_sh_q <= r_sh_d;
                    // The counter parks on the last bit so no wrap is ever visible.
                    if (cnt_q == LAST) begin
                        sum_q   <= r_sh_d;
                        carry_q <= c_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_out  = (state_q != IDLE);
    assign done_out  = done_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 scenarios plus an exhaustive
// WIDTH=2 sweep with start held high.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2, done2, carry2;
    logic [1:0] sum2;

    int total = 0;
    int bad   = 0;
    logic [8:0] prev8 = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_in(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
        .busy_out(busy8), .done_out(done8), .sum_out(sum8), .carry_out(carry8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start_in(start2), .a_in(a2), .b_in(b2), .cin_in(cin2),
        .busy_out(busy2), .done_out(done2), .sum_out(sum2), .carry_out(carry2)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cin8   = cin;
    endtask

    // Inputs are already set up; the next rising edge accepts the start.
    task automatic run8(input logic [8:0] exp, input bit disturb, input string tag);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 0; n <= 8; n++) begin
            if (disturb && n == 3) begin
                start8 = 1'b1;
                a8     = 8'h12;
                b8     = 8'h34;
                cin8   = 1'b0;
            end
            if (disturb && n == 5) start8 = 1'b0;
            check({tag, "_busy"}, 33'(busy8), 33'd1);
            check({tag, "_done"}, 33'(done8), 33'(n == 8));
            if (n < 8) check({tag, "_hold"}, 33'({carry8, sum8}), 33'(prev8));
            else       check({tag, "_result"}, 33'({carry8, sum8}), 33'(exp));
            if (n < 8) @(negedge clk);
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, 33'(busy8), 33'd0);
        check({tag, "_idle_done"}, 33'(done8), 33'd0);
        check({tag, "_after"}, 33'({carry8, sum8}), 33'(exp));
        prev8 = exp;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy", 33'(busy8), 33'd0);
        check("rst_done", 33'(done8), 33'd0);
        check("rst_res",  33'({carry8, sum8}), 33'd0);
        check("rst_w2",   33'({busy2, done2, carry2, sum2}), 33'd0);
        @(negedge clk);
        rst = 1'b0;

        launch8(8'h00, 8'h00, 1'b0);
        run8(9'h000, 1'b0, "zero");
        launch8(8'hFF, 8'h01, 1'b0);
        run8(9'h100, 1'b0, "ff_01");
        launch8(8'h5A, 8'h3C, 1'b1);
        run8(9'h097, 1'b0, "5a_3c_c");
        launch8(8'hFF, 8'hFF, 1'b1);
        run8(9'h1FF, 1'b1, "ff_ff_c_disturb");
        repeat (4) begin
            @(negedge clk);
            check("no_second_done", 33'(done8), 33'd0);
            check("no_second_busy", 33'(busy8), 33'd0);
        end

        // Abort mid-operation with an asynchronous reset
        launch8(8'h80, 8'h80, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 33'(busy8), 33'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 33'(busy8), 33'd0);
        check("abort_done", 33'(done8), 33'd0);
        check("abort_res",  33'({carry8, sum8}), 33'd0);
        prev8 = '0;
        repeat (3) begin
            @(negedge clk);
            check("abort_hold_done", 33'(done8), 33'd0);
        end
        rst    = 1'b0;
        start8 = 1'b1;
        a8     = 8'h80;
        b8     = 8'h80;
        cin8   = 1'b0;
        run8(9'h100, 1'b0, "post_rst_80_80");

        // WIDTH=2 exhaustive with start held high
        @(negedge clk);
        start2 = 1'b1;
        {a2, b2, cin2} = 5'd0;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            logic [2:0] exp2;
            v = 5'(i);
            exp2 = 3'(v[4:3]) + 3'(v[2:1]) + 3'(v[0]);
            @(posedge clk);
            @(negedge clk);
            if (i == 31) start2 = 1'b0;
            else {a2, b2, cin2} = 5'(i + 1);
            for (int n = 0; n < 4; n++) begin
                check("w2_done", 33'(done2), 33'(n == 2));
                if (n == 2) check("w2_result", 33'({carry2, sum2}), 33'(exp2));
                if (n < 3) @(negedge clk);
            end
        end
        @(negedge clk);
        check("w2_idle_busy", 33'(busy2), 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #90000;
        bad++;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
